// File: rtl/leb128_fetch.sv
// leb128_fetch: operand-fetch stage that reads one LEB128 immediate from the
// byte-window ROM and decodes it serially at one byte per cycle.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               request strobe, sampled only in idle
//   addr                byte address of the first LEB128 byte
//   is_signed, width64  sLEB128 / uLEB128 select and 64/32-bit immediate select
//   busy, done          handshake: busy while working, done one-cycle pulse
//   value, length,      decoded immediate, bytes consumed and error code
//   error               (0 OK, 1 MEM, 2 TOO_LONG, 3 BAD_BITS, 4 NO_64B)
//   mem_addr, mem_extra ROM request (window size minus one in mem_extra)
//   mem_data, mem_error ROM window and bounds error, one cycle after request
module leb128_fetch #(
    parameter int unsigned MEM_DEPTH = 6,
    parameter int unsigned MEM_EXTRA = 4,
    parameter bit          USE_64B   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MEM_DEPTH:0]            addr,
    input  logic                          is_signed,
    input  logic                          width64,
    output logic                          busy,
    output logic                          done,
    output logic [63:0]                   value,
    output logic [3:0]                    length,
    output logic [2:0]                    error,
    output logic [MEM_DEPTH:0]            mem_addr,
    output logic [MEM_EXTRA-1:0]          mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
    input  logic                          mem_error
);

    localparam int unsigned WinW = (2**MEM_EXTRA) * 8;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StDecode = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam logic [2:0] ErrOk      = 3'd0;
    localparam logic [2:0] ErrMem     = 3'd1;
    localparam logic [2:0] ErrTooLong = 3'd2;
    localparam logic [2:0] ErrBadBits = 3'd3;
    localparam logic [2:0] ErrNo64b   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [MEM_DEPTH:0]   addr_q, addr_d;
    logic                 signed_q, signed_d;
    logic                 wide_q, wide_d;
    // Request rejected up front (64-bit without 64-bit support)
    logic                 rej_q, rej_d;
    logic [WinW-1:0]      win_q, win_d;
    logic [3:0]           idx_q, idx_d;
    logic [63:0]          acc_q, acc_d;
    logic [63:0]          value_q, value_d;
    logic [3:0]           length_q, length_d;
    logic [2:0]           error_q, error_d;

    logic [3:0]  maxb;
    logic [7:0]  cur;
    logic [6:0]  sh;
    logic [63:0] acc_next;
    logic        last;
    logic        bad_bits;
    logic [3:0]  len_next;
    logic [6:0]  sh_len;
    logic [63:0] sign_src;
    logic [63:0] ext_mask;
    logic [63:0] fin_val;

    // Decode datapath for the byte under the cursor
    always_comb begin
        maxb     = wide_q ? 4'd10 : 4'd5;
        cur      = win_q[8*int'(idx_q) +: 8];
        sh       = 7'(idx_q) * 7'd7;
        acc_next = acc_q | ({57'b0, cur[6:0]} << sh);
        last     = (idx_q == maxb - 4'd1);
        len_next = idx_q + 4'd1;

        if (!wide_q) begin
            bad_bits = signed_q ? (cur[6:4] != {3{cur[3]}}) : (cur[6:4] != 3'b000);
        end else begin
            bad_bits = signed_q ? !(cur[6:0] == 7'h00 || cur[6:0] == 7'h7f)
                                : (cur[6:1] != 6'b0);
        end

        // Sign-extend from bit 7*len-1; a 10-byte encoding already fills 64 bits
        sh_len   = 7'(len_next) * 7'd7;
        sign_src = acc_next >> (sh_len - 7'd1);
        ext_mask = (sh_len >= 7'd64) ? 64'b0 : ({64{1'b1}} << sh_len);
        fin_val  = acc_next;
        if (signed_q && sign_src[0]) begin
            fin_val = fin_val | ext_mask;
        end
        if (!wide_q) begin
            fin_val[63:32] = signed_q ? {32{fin_val[31]}} : 32'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        signed_d = signed_q;
        wide_d   = wide_q;
        rej_d    = rej_q;
        win_d    = win_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        value_d  = value_q;
        length_d = length_q;
        error_d  = error_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = addr;
                    signed_d = is_signed;
                    wide_d   = width64;
                    rej_d    = width64 && !USE_64B;
                    idx_d    = 4'd0;
                    acc_d    = 64'b0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                // A rejected request spends this cycle busy without touching the ROM
                if (rej_q) begin
                    value_d  = 64'b0;
                    length_d = 4'd0;
                    error_d  = ErrNo64b;
                    state_d  = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                win_d = mem_data;
                if (mem_error) begin
                    value_d  = 64'b0;
                    length_d = 4'd0;
                    error_d  = ErrMem;
                    state_d  = StDone;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!cur[7] || last) begin
                    value_d  = fin_val;
                    length_d = len_next;
                    if (cur[7]) begin
                        error_d = ErrTooLong;
                    end else if (last && bad_bits) begin
                        error_d = ErrBadBits;
                    end else begin
                        error_d = ErrOk;
                    end
                    state_d = StDone;
                end else begin
                    acc_d = acc_next;
                    idx_d = len_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            signed_q <= 1'b0;
            wide_q   <= 1'b0;
            rej_q    <= 1'b0;
            win_q    <= '0;
            idx_q    <= 4'd0;
            acc_q    <= 64'b0;
            value_q  <= 64'b0;
            length_q <= 4'd0;
            error_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            signed_q <= signed_d;
            wide_q   <= wide_d;
            rej_q    <= rej_d;
            win_q    <= win_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            value_q  <= value_d;
            length_q <= length_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        busy   = (state_q == StFetch) || (state_q == StWait) || (state_q == StDecode);
        done   = (state_q == StDone);
        value  = value_q;
        length = length_q;
        error  = error_q;
        if ((state_q == StFetch || state_q == StWait) && !rej_q) begin
            mem_addr  = addr_q;
            mem_extra = wide_q ? MEM_EXTRA'(9) : MEM_EXTRA'(4);
        end else begin
            mem_addr  = '0;
            mem_extra = '0;
        end
    end

endmodule

// File: tb/tb_leb128_fetch.sv
// Bench for leb128_fetch: ROM model plus a reference decoder working on whole
// byte sequences with wide arithmetic; directed cases followed by random ones.
module tb_leb128_fetch;

    localparam int WB = 16;

    logic          clk = 1'b0;
    logic          reset, start, is_signed, width64;
    logic [6:0]    addr;
    logic          busy, done;
    logic [63:0]   value;
    logic [3:0]    length;
    logic [2:0]    error;
    logic [6:0]    mem_addr;
    logic [3:0]    mem_extra;
    logic [WB*8-1:0] mem_data;
    logic          mem_error;

    // Second instance without 64-bit support; it never needs the ROM
    logic          start_b, width64_b;
    logic          busy_b, done_b;
    logic [63:0]   value_b;
    logic [3:0]    length_b;
    logic [2:0]    error_b;
    logic [6:0]    mem_addr_b;
    logic [3:0]    mem_extra_b;
    logic [WB*8-1:0] mem_data_b = '0;
    logic          mem_error_b = 1'b0;

    logic [7:0] rom [0:127];
    int         upper = 127;
    int         cyc = 0;
    int         ncmp = 0;
    int         nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4), .USE_64B(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .is_signed(is_signed),
        .width64(width64), .busy(busy), .done(done), .value(value), .length(length),
        .error(error), .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data),
        .mem_error(mem_error)
    );

    leb128_fetch #(.MEM_DEPTH(6), .MEM_EXTRA(4), .USE_64B(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .addr(7'd0), .is_signed(1'b0),
        .width64(width64_b), .busy(busy_b), .done(done_b), .value(value_b),
        .length(length_b), .error(error_b), .mem_addr(mem_addr_b), .mem_extra(mem_extra_b),
        .mem_data(mem_data_b), .mem_error(mem_error_b)
    );

    // ROM: registered window read and bounds error
    always @(posedge clk) begin
        for (int k = 0; k < WB; k++) begin
            mem_data[8*k +: 8] <= (int'(mem_addr) + k < 128) ? rom[int'(mem_addr) + k] : 8'h00;
        end
        mem_error <= (int'(mem_addr) + int'(mem_extra)) > upper;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit final_ok(input int p, input bit sg, input bit w);
        if (!w) return sg ? (p <= 7 || p >= 120) : (p < 16);
        return sg ? (p == 0 || p == 127) : (p <= 1);
    endfunction

    function automatic void model(input int a, input bit sg, input bit w, input bit use64,
                                  output logic [63:0] v, output int len, output int err,
                                  output int lat);
        int maxb;
        int n;
        int p;
        logic [7:0] b;
        logic [127:0] big;
        v = 64'b0; len = 0; err = 0; lat = 0;
        if (w && !use64) begin
            err = 4; lat = 2;
            return;
        end
        maxb = w ? 10 : 5;
        if (a + maxb - 1 > upper) begin
            err = 1; lat = 3;
            return;
        end
        big = '0;
        n = 0;
        for (int i = 0; i < maxb; i++) begin
            b = rom[a + i];
            p = int'(b[6:0]);
            big = big + (128'(p) << (7 * i));
            n = i + 1;
            if (b < 8'h80) begin
                if (i == maxb - 1 && !final_ok(p, sg, w)) err = 3;
                break;
            end
            if (i == maxb - 1) err = 2;
        end
        if (sg && big[7*n-1]) big = big - (128'(1) << (7 * n));
        v = big[63:0];
        if (!w) v = sg ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
        len = n;
        lat = 3 + n;
    endfunction

    // One request on the main instance, fully checked against the model
    task automatic run_req(input string tag, input int a, input bit sg, input bit w);
        logic [63:0] ev;
        int el, ee, elat, t0, lat;
        model(a, sg, w, 1'b1, ev, el, ee, elat);
        @(negedge clk);
        addr = 7'(a); is_signed = sg; width64 = w; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy1"}, 64'(busy), 64'd1);
        check({tag, ".mextra"}, 64'(mem_extra), w ? 64'd9 : 64'd4);
        check({tag, ".maddr"}, 64'(mem_addr), 64'(a));
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".value"}, value, ev);
        check({tag, ".len"}, 64'(length), 64'(el));
        check({tag, ".err"}, 64'(error), 64'(ee));
        check({tag, ".busy0"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, ".pulse"}, 64'(done), 64'd0);
        check({tag, ".hold"}, value, ev);
        check({tag, ".mextra0"}, 64'(mem_extra), 64'd0);
    endtask

    initial begin
        logic [63:0] rv;
        int t0, lat, ndone, a, n, maxb, rl, re, rlat;
        bit sg, w;

        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        reset = 1'b1; start = 1'b0; addr = '0; is_signed = 1'b0; width64 = 1'b0;
        start_b = 1'b0; width64_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.value", value, 64'd0);
        check("rst.len", 64'(length), 64'd0);
        check("rst.err", 64'(error), 64'd0);
        check("rst.maddr", 64'(mem_addr), 64'd0);
        check("rst.mextra", 64'(mem_extra), 64'd0);

        // 1: E5 8E 26 -> 624485
        rom[10] = 8'hE5; rom[11] = 8'h8E; rom[12] = 8'h26;
        run_req("t1", 10, 1'b0, 1'b0);
        check("t1.const", value, 64'd624485);

        // 2: 7F signed 64-bit -> -1
        rom[20] = 8'h7F;
        run_req("t2", 20, 1'b1, 1'b1);
        check("t2.const", value, 64'hFFFF_FFFF_FFFF_FFFF);

        // 3: max u32, then bad final bits
        rom[30] = 8'hFF; rom[31] = 8'hFF; rom[32] = 8'hFF; rom[33] = 8'hFF; rom[34] = 8'h0F;
        run_req("t3a", 30, 1'b0, 1'b0);
        check("t3a.const", value, 64'h0000_0000_FFFF_FFFF);
        rom[34] = 8'h1F;
        run_req("t3b", 30, 1'b0, 1'b0);
        check("t3b.const", 64'(error), 64'd3);

        // 6: reset during decode of a 5-byte encoding
        rom[40] = 8'hFF; rom[41] = 8'hFF; rom[42] = 8'hFF; rom[43] = 8'hFF; rom[44] = 8'h07;
        @(negedge clk);
        addr = 7'd40; is_signed = 1'b0; width64 = 1'b0; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6.busy", 64'(busy), 64'd0);
        check("t6.done", 64'(done), 64'd0);
        check("t6.value", value, 64'd0);
        check("t6.err", 64'(error), 64'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6.nodone", 64'(ndone), 64'd0);
        run_req("t6b", 40, 1'b0, 1'b0);

        // 4: ten bytes, all continuation -> TOO_LONG
        for (int i = 0; i < 10; i++) rom[50 + i] = 8'h80;
        rom[60] = 8'h01;
        run_req("t4", 50, 1'b0, 1'b1);
        check("t4.const", 64'(error), 64'd2);

        // 5: bounds error, then 64-bit request on the instance without support
        upper = 9;
        run_req("t5a", 10, 1'b0, 1'b0);
        check("t5a.const", 64'(error), 64'd1);
        upper = 127;
        @(negedge clk);
        width64_b = 1'b1; start_b = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done_b) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        model(0, 1'b0, 1'b1, 1'b0, rv, rl, re, rlat);
        check("t5b.lat", 64'(lat), 64'(rlat));
        check("t5b.err", 64'(error_b), 64'(re));
        check("t5b.len", 64'(length_b), 64'(rl));
        check("t5b.mextra", 64'(mem_extra_b), 64'd0);

        // Random encodings, occasional bad tails and out-of-bounds windows
        for (int r = 0; r < 40; r++) begin
            a = int'($urandom_range(0, 100));
            sg = 1'($urandom);
            w = 1'($urandom);
            maxb = w ? 10 : 5;
            n = int'($urandom_range(1, maxb));
            for (int i = 0; i < 10; i++) begin
                rom[a + i] = 8'($urandom);
                if (i < n - 1) rom[a + i][7] = 1'b1;
                else if (i == n - 1 && $urandom_range(0, 7) != 0) rom[a + i][7] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) upper = a + int'($urandom_range(0, maxb - 2));
            else upper = 127;
            run_req($sformatf("rnd%0d", r), a, sg, w);
        end
        upper = 127;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
